// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Multi-cycle multiply/accumulate and radix-2 restoring divide with
//            HI/LO result registers, Start/Busy/Done handshake and flush.
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    input  logic             HiWe,
    input  logic             LoWe,
    input  logic [WIDTH-1:0] WData,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + MUL_STAGES) + 1;
    localparam logic [CNT_W-1:0] c_mul_last = CNT_W'(MUL_STAGES - 2);
    localparam logic [CNT_W-1:0] c_div_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_dbz;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;
    logic [1:0]        r_mop;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_dvd;
    logic [WIDTH-1:0]  r_dvs;
    logic [WIDTH-1:0]  r_rem;
    logic [WIDTH-1:0]  r_a;
    logic              r_dz;
    logic              r_negq;
    logic              r_negr;

    logic              w_accept;
    logic              w_is_div;
    logic              w_signed;
    logic              w_wr_hi;
    logic              w_wr_lo;
    logic [WIDTH-1:0]  w_hi_eff;
    logic [WIDTH-1:0]  w_lo_eff;
    logic [PW-1:0]     w_a_ext;
    logic [PW-1:0]     w_b_ext;
    logic [PW-1:0]     w_prod_now;
    logic [PW-1:0]     w_prod_fin;
    logic [1:0]        w_mul_op;
    logic [PW-1:0]     w_acc;
    logic [PW-1:0]     w_mul_res;
    logic [WIDTH-1:0]  w_neg_a;
    logic [WIDTH-1:0]  w_neg_b;
    logic [WIDTH-1:0]  w_a_mag;
    logic [WIDTH-1:0]  w_b_mag;
    logic [WIDTH:0]    w_rem_sh;
    logic [WIDTH:0]    w_diff;
    logic              w_qbit;
    logic [WIDTH-1:0]  w_rem_nx;
    logic [WIDTH-1:0]  w_quo_nx;
    logic [WIDTH-1:0]  w_quo_fix;
    logic [WIDTH-1:0]  w_rem_fix;

    assign w_accept = Start & ~Flush & ~r_busy;
    assign w_is_div = Op[2] & Op[1];
    assign w_signed = ~Op[0];
    assign w_wr_hi  = HiWe & ~r_busy;
    assign w_wr_lo  = LoWe & ~r_busy;

    // Direct writes take effect before an op issued in the same cycle reads HI/LO.
    assign w_hi_eff = w_wr_hi ? WData : r_hi;
    assign w_lo_eff = w_wr_lo ? WData : r_lo;
    assign w_acc    = {w_hi_eff, w_lo_eff};

    assign w_a_ext    = {{WIDTH{w_signed & A[WIDTH-1]}}, A};
    assign w_b_ext    = {{WIDTH{w_signed & B[WIDTH-1]}}, B};
    assign w_prod_now = w_a_ext * w_b_ext;

    generate
        if (MUL_STAGES > 1) begin : g_pipe
            logic [PW-1:0] r_pipe [MUL_STAGES-1];

            always_ff @(posedge Clock or negedge nReset) begin
                if (!nReset) begin
                    for (int i = 0; i < MUL_STAGES - 1; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    if (w_accept && !w_is_div) begin
                        r_pipe[0] <= w_prod_now;
                    end
                    for (int i = 1; i < MUL_STAGES - 1; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_prod_fin = r_pipe[MUL_STAGES-2];
            assign w_mul_op   = r_mop;
        end else begin : g_comb
            assign w_prod_fin = w_prod_now;
            assign w_mul_op   = Op[2:1];
        end
    endgenerate

    always_comb begin
        w_mul_res = w_prod_fin;
        case (w_mul_op)
            2'b01:   w_mul_res = w_acc + w_prod_fin;
            2'b10:   w_mul_res = w_acc - w_prod_fin;
            default: w_mul_res = w_prod_fin;
        endcase
    end

    // Divide runs on magnitudes; signs are restored on the final iteration.
    assign w_neg_a  = -A;
    assign w_neg_b  = -B;
    assign w_a_mag  = (w_signed & A[WIDTH-1]) ? w_neg_a : A;
    assign w_b_mag  = (w_signed & B[WIDTH-1]) ? w_neg_b : B;

    assign w_rem_sh  = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_dvs};
    assign w_qbit    = ~w_diff[WIDTH];
    assign w_rem_nx  = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx  = {r_dvd[WIDTH-2:0], w_qbit};
    assign w_quo_fix = r_negq ? -w_quo_nx : w_quo_nx;
    assign w_rem_fix = r_negr ? -w_rem_nx : w_rem_nx;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_mop   <= '0;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_rem   <= '0;
            r_a     <= '0;
            r_dz    <= 1'b0;
            r_negq  <= 1'b0;
            r_negr  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            if (w_wr_hi) r_hi <= WData;
            if (w_wr_lo) r_lo <= WData;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mop <= Op[2:1];
                        r_cnt <= '0;
                        if (w_is_div) begin
                            r_state <= S_DIV;
                            r_busy  <= 1'b1;
                            r_dvd   <= w_a_mag;
                            r_dvs   <= w_b_mag;
                            r_rem   <= '0;
                            r_a     <= A;
                            r_dz    <= (B == '0);
                            r_negq  <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            r_negr  <= w_signed & A[WIDTH-1];
                        end else if (MUL_STAGES == 1) begin
                            {r_hi, r_lo} <= w_mul_res;
                            r_done       <= 1'b1;
                        end else begin
                            r_state <= S_MUL;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                S_MUL: begin
                    if (Flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == c_mul_last) begin
                        {r_hi, r_lo} <= w_mul_res;
                        r_done       <= 1'b1;
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                S_DIV: begin
                    if (Flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == c_div_last) begin
                        r_lo    <= r_dz ? {WIDTH{1'b1}} : w_quo_fix;
                        r_hi    <= r_dz ? r_a : w_rem_fix;
                        r_dbz   <= r_dz;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_dvd <= w_quo_nx;
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Done      = r_done;
    assign DivByZero = r_dbz;
    assign Hi        = r_hi;
    assign Lo        = r_lo;

endmodule
`default_nettype wire
